rr_mux: RTL and testbench
=========================

RR_MUX -- requirements
Module: rr_mux

Interface
REQ-001 Parameter CHANNELS, default 4, number of input channels (>= 1).
REQ-002 Parameter BUS_SIZE, default 32, data width in bits per channel.
REQ-003 Parameter ROUND_ROBIN, default 1; 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
REQ-004 Derived constant SEL_W = max(1, clog2(CHANNELS)).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  CHANNELS  per-channel request, bit i = channel i holds a word.
REQ-008 data_in  input  CHANNELS x BUS_SIZE (unpacked array)  per-channel data.
REQ-009 in_ready  output  CHANNELS  per-channel accept; bit i high = channel i transfers this cycle.
REQ-010 out_valid  output  1  data_out holds a valid word.
REQ-011 out_ready  input  1  downstream accepts the word this cycle.
REQ-012 data_out  output  BUS_SIZE  registered selected word.
REQ-013 grant_idx  output  SEL_W  index of the channel that supplied data_out.

Function
REQ-014 Single output register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 load_en = !out_valid | out_ready; in_ready is all-zero when load_en=0.
REQ-016 When load_en=1 and in_valid != 0, exactly one in_ready bit is high, that of the granted channel g, combinationally from current inputs and state.
REQ-017 Transfer occurs on channel g when in_valid[g] & in_ready[g]; at that edge data_out <= data_in[g], grant_idx <= g, out_valid <= 1 (latency 1 cycle).
REQ-018 When load_en=1 and in_valid=0: out_valid <= 0 on that edge; data_out and grant_idx hold.
REQ-019 While out_valid=1 and out_ready=0, data_out, grant_idx and out_valid hold unchanged.
REQ-020 Simultaneous out_ready=1 and new transfer: old word retires and new word loads in the same edge (sustained 1 word/cycle).
REQ-021 Round-robin: priority pointer ptr (SEL_W bits); grant = first requesting channel searching ptr, ptr+1, ... with wrap-around modulo CHANNELS.
REQ-022 After each transfer from g, ptr <= (g+1) mod CHANNELS; ptr holds when no transfer occurs.
REQ-023 ROUND_ROBIN=0: grant = lowest-index requesting channel; ptr unused and held at 0.
REQ-024 CHANNELS=1: grant always 0, grant_idx constant 0; behaves as a one-stage valid/ready register.
REQ-025 No channel starves in round-robin mode: with all channels requesting continuously, each is granted once per CHANNELS transfers.

Reset
REQ-026 reset asserted: out_valid=0, data_out=0, grant_idx=0, ptr=0 immediately, independent of clk.
REQ-027 in_ready SHALL be forced all-zero while reset is high.
REQ-028 Reset mid-transfer discards the held word; first grant after release starts search at channel 0.

Structure
REQ-029 Defaults DEFAULT_RR_MUX_CHANNELS, DEFAULT_RR_MUX_BUS_SIZE, DEFAULT_RR_MUX_ROUND_ROBIN SHALL live in shared header rr_mux.vh.
REQ-030 Grant logic SHALL be a combinational sub-module rr_arbiter (inputs: request vector, ptr, mode; outputs: one-hot grant, grant index, any_grant).

Verification
REQ-031 Reset mid-FULL: load word 0xA5A5A5A5 from ch2, assert reset with out_ready=0 -> out_valid=0, data_out=0, in_ready=0 immediately; after release ch3 and ch0 requesting -> ch0 granted first.
REQ-032 RR rotation: CHANNELS=4, all in_valid=1, out_ready=1, data_in[i]=i -> grant_idx sequence 0,1,2,3,0,1 on consecutive cycles, out_valid continuously 1.
REQ-033 Wrap-around: ptr=3 (after ch2 grant), requests on ch1 and ch2 only -> ch1 granted, ptr becomes 2.
REQ-034 Backpressure: out_ready=0 for 5 cycles while ch1 requests -> in_ready=0 and data_out stable all 5 cycles; out_ready=1 -> word from ch1 loads next edge.
REQ-035 Fixed priority (ROUND_ROBIN=0): ch0 and ch3 requesting continuously, out_ready=1 -> grant_idx stays 0; ch3 granted only after ch0 drops in_valid.
REQ-036 Drain: single word in FULL, out_ready=1, no in_valid -> out_valid=0 next edge, data_out retains last value.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Common types, defaults and helpers for the round-robin output mux.
`include "rr_mux.vh"

package rr_mux_pkg;

  localparam int RR_MUX_DEF_CHANNELS    = `DEFAULT_RR_MUX_CHANNELS;
  localparam int RR_MUX_DEF_BUS_SIZE    = `DEFAULT_RR_MUX_BUS_SIZE;
  localparam int RR_MUX_DEF_ROUND_ROBIN = `DEFAULT_RR_MUX_ROUND_ROBIN;

  // Output register occupancy.
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Index width; a single channel still needs a 1-bit index port.
  function automatic int sel_w(input int c);
    return (c > 1) ? $clog2(c) : 1;
  endfunction

endpackage

// File: rtl/rr_mux_if.sv
// Channel-side and output-side handshake bundle of rr_mux.
interface rr_mux_if
  import rr_mux_pkg::*;
#(
  parameter int CHANNELS = RR_MUX_DEF_CHANNELS,
  parameter int BUS_SIZE = RR_MUX_DEF_BUS_SIZE
);
  localparam int SEL_W = sel_w(CHANNELS);

  // A word moves when valid and ready are both high at a rising clk edge;
  // valid/data must hold until accepted, ready may depend on valid.
  logic [CHANNELS-1:0] in_valid;
  logic [BUS_SIZE-1:0] data_in [CHANNELS];
  logic [CHANNELS-1:0] in_ready;
  logic                out_valid;
  logic                out_ready;
  logic [BUS_SIZE-1:0] data_out;
  logic [SEL_W-1:0]    grant_idx;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, grant_idx
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, grant_idx
  );

endinterface

// File: rtl/rr_mux.vh
// Shared build-time defaults for the rr_mux block.
`ifndef RR_MUX_VH
`define RR_MUX_VH
`define DEFAULT_RR_MUX_CHANNELS    4
`define DEFAULT_RR_MUX_BUS_SIZE    32
`define DEFAULT_RR_MUX_ROUND_ROBIN 1
`endif

// File: rtl/rr_mux_arbiter.sv
// Combinational grant search: first requester at or after ptr (rr_mode=1),
// or lowest requesting index (rr_mode=0).
module rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  input  logic                rr_mode,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx,
  output logic                any_grant
);

  int base;
  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    base      = rr_mode ? int'(ptr) : 0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = (base + i) % CHANNELS;
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_mux.sv
// N-to-1 valid/ready mux with a single output register and round-robin
// or fixed-priority arbitration.
module rr_mux
  import rr_mux_pkg::*;
#(
  parameter int CHANNELS    = RR_MUX_DEF_CHANNELS,
  parameter int BUS_SIZE    = RR_MUX_DEF_BUS_SIZE,
  parameter int ROUND_ROBIN = RR_MUX_DEF_ROUND_ROBIN,
  localparam int SEL_W      = sel_w(CHANNELS)
) (
  input  logic             clk,
  input  logic             reset,
  rr_mux_if.slave          bus,
  output state_t           dbg_state,
  output logic [SEL_W-1:0] dbg_ptr
);

  state_t              state, state_nxt;
  logic [SEL_W-1:0]    ptr, ptr_nxt;
  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    gnt_idx;
  logic                any_grant;
  logic                load_en;
  logic                xfer;
  logic [BUS_SIZE-1:0] sel_data;
  logic [BUS_SIZE-1:0] data_q;
  logic [SEL_W-1:0]    gidx_q;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_arb (
    .req       (bus.in_valid),
    .ptr       (ptr),
    .rr_mode   (ROUND_ROBIN != 0),
    .grant     (grant),
    .grant_idx (gnt_idx),
    .any_grant (any_grant)
  );

  // The register can take a word when empty or when its word leaves now.
  assign load_en      = (state == ST_EMPTY) || bus.out_ready;
  assign xfer         = load_en && any_grant;
  assign bus.in_ready = (reset || !load_en) ? '0 : grant;
  assign bus.out_valid = (state == ST_FULL);
  assign bus.data_out  = data_q;
  assign bus.grant_idx = gidx_q;
  assign dbg_state     = state;
  assign dbg_ptr       = ptr;

  // One-hot AND-OR select avoids indexing by a possibly out-of-range index.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) sel_data = sel_data | bus.data_in[i];
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    if (load_en) begin
      if (any_grant) begin
        state_nxt = ST_FULL;
        if (ROUND_ROBIN != 0)
          ptr_nxt = (gnt_idx == SEL_W'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
        else
          ptr_nxt = '0;
      end else begin
        state_nxt = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_EMPTY;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Payload only moves on a transfer; a drain leaves the last word visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      gidx_q <= '0;
    end else if (xfer) begin
      data_q <= sel_data;
      gidx_q <= gnt_idx;
    end
  end

endmodule

// File: tb/tb_rr_mux.sv
// Directed + random bench for rr_mux: round-robin instance with a scoreboard
// model, plus a fixed-priority instance.
module tb_rr_mux;
  import rr_mux_pkg::*;

  logic clk;
  logic reset;

  rr_mux_if #(.CHANNELS(4), .BUS_SIZE(32)) rr_bus ();
  rr_mux_if #(.CHANNELS(4), .BUS_SIZE(32)) fp_bus ();

  state_t     rr_state, fp_state;
  logic [1:0] rr_ptr, fp_ptr;

  rr_mux #(.CHANNELS(4), .BUS_SIZE(32), .ROUND_ROBIN(1)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .bus       (rr_bus),
    .dbg_state (rr_state),
    .dbg_ptr   (rr_ptr)
  );

  rr_mux #(.CHANNELS(4), .BUS_SIZE(32), .ROUND_ROBIN(0)) u_fp (
    .clk       (clk),
    .reset     (reset),
    .bus       (fp_bus),
    .dbg_state (fp_state),
    .dbg_ptr   (fp_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard and reference state
  logic [33:0] exp_q[$];
  int          vectors = 0;
  int          fails   = 0;
  logic        m_full  = 1'b0;
  int          mptr    = 0;
  logic [31:0] m_data  = '0;
  logic [1:0]  m_gidx  = '0;
  int          rot_exp [6] = '{0, 1, 2, 3, 0, 1};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [3:0] v, input int p);
    for (int i = 0; i < 4; i++) begin
      if (v[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  task automatic rand_data();
    for (int i = 0; i < 4; i++) rr_bus.data_in[i] = $urandom;
  endtask

  // Drive one cycle from a negedge, check comb in_ready, then check outputs
  // at the following negedge.
  task automatic step(input logic [3:0] v, input logic ordy);
    logic        load;
    int          g;
    logic [3:0]  exp_rdy;
    logic [33:0] e;
    rr_bus.in_valid  = v;
    rr_bus.out_ready = ordy;
    #1;
    load    = !m_full || ordy;
    g       = model_grant(v, mptr);
    exp_rdy = (load && g >= 0) ? 4'(1 << g) : 4'h0;
    check("in_ready", 64'(rr_bus.in_ready), 64'(exp_rdy));
    if (load && g >= 0) begin
      exp_q.push_back({2'(g), rr_bus.data_in[g]});
      mptr   = (g + 1) % 4;
      m_full = 1'b1;
    end else if (load) begin
      m_full = 1'b0;
    end
    @(negedge clk);
    check("out_valid", 64'(rr_bus.out_valid), 64'(m_full));
    if (exp_q.size() > 0) begin
      e      = exp_q.pop_front();
      m_gidx = e[33:32];
      m_data = e[31:0];
    end
    check("data_out", 64'(rr_bus.data_out), 64'(m_data));
    check("grant_idx", 64'(rr_bus.grant_idx), 64'(m_gidx));
    check("ptr", 64'(rr_ptr), 64'(mptr));
  endtask

  initial begin
    reset            = 1'b0;
    rr_bus.in_valid  = '0;
    rr_bus.out_ready = 1'b0;
    fp_bus.in_valid  = '0;
    fp_bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rr_bus.data_in[i] = '0;
      fp_bus.data_in[i] = 32'hF0 + i;
    end

    // reset state, in_ready forced low while reset is high
    #1 reset = 1'b1;
    rr_bus.in_valid  = 4'hF;
    rr_bus.out_ready = 1'b1;
    #2;
    check("rst_out_valid", 64'(rr_bus.out_valid), 64'd0);
    check("rst_data_out", 64'(rr_bus.data_out), 64'd0);
    check("rst_grant_idx", 64'(rr_bus.grant_idx), 64'd0);
    check("rst_in_ready", 64'(rr_bus.in_ready), 64'd0);
    check("rst_state", 64'(rr_state), 64'(ST_EMPTY));
    @(negedge clk);
    reset = 1'b0;

    // rotation: all channels requesting, data_in[i]=i
    for (int i = 0; i < 4; i++) rr_bus.data_in[i] = 32'(i);
    for (int k = 0; k < 6; k++) begin
      step(4'hF, 1'b1);
      check("rot_seq", 64'(rr_bus.grant_idx), 64'(rot_exp[k]));
    end

    // drain: word retires, data_out keeps its value
    step(4'h0, 1'b1);
    check("drain_data", 64'(rr_bus.data_out), 64'd1);

    // wrap-around: ch2 grant leaves ptr=3, then ch1|ch2 -> ch1, ptr=2
    rand_data();
    step(4'b0100, 1'b1);
    rand_data();
    step(4'b0110, 1'b1);
    check("wrap_gidx", 64'(rr_bus.grant_idx), 64'd1);
    check("wrap_ptr", 64'(rr_ptr), 64'd2);

    // backpressure: five stalled cycles, then the ch1 word loads
    rand_data();
    for (int k = 0; k < 5; k++) step(4'b0010, 1'b0);
    step(4'b0010, 1'b1);
    check("bp_gidx", 64'(rr_bus.grant_idx), 64'd1);

    // random traffic
    for (int k = 0; k < 40; k++) begin
      rand_data();
      step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    // reset while FULL: held word discarded, search restarts at ch0
    step(4'h0, 1'b1);
    rr_bus.data_in[2] = 32'hA5A5_A5A5;
    step(4'b0100, 1'b0);
    check("pre_rst_data", 64'(rr_bus.data_out), 64'hA5A5_A5A5);
    rr_bus.in_valid  = 4'hF;
    rr_bus.out_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(rr_bus.out_valid), 64'd0);
    check("mid_rst_data", 64'(rr_bus.data_out), 64'd0);
    check("mid_rst_in_ready", 64'(rr_bus.in_ready), 64'd0);
    @(negedge clk);
    reset  = 1'b0;
    m_full = 1'b0;
    mptr   = 0;
    m_data = '0;
    m_gidx = '0;
    rand_data();
    step(4'b1001, 1'b1);
    check("post_rst_gidx", 64'(rr_bus.grant_idx), 64'd0);

    // fixed priority: ch0 wins while requesting, ch3 only after ch0 drops
    fp_bus.in_valid  = 4'b1001;
    fp_bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("fp_in_ready", 64'(fp_bus.in_ready), 64'h1);
      @(negedge clk);
      check("fp_out_valid", 64'(fp_bus.out_valid), 64'd1);
      check("fp_gidx", 64'(fp_bus.grant_idx), 64'd0);
      check("fp_data", 64'(fp_bus.data_out), 64'hF0);
    end
    fp_bus.in_valid = 4'b1000;
    #1;
    check("fp_in_ready3", 64'(fp_bus.in_ready), 64'h8);
    @(negedge clk);
    check("fp_gidx3", 64'(fp_bus.grant_idx), 64'd3);
    check("fp_data3", 64'(fp_bus.data_out), 64'hF3);
    check("fp_ptr", 64'(fp_ptr), 64'd0);
    check("fp_state", 64'(fp_state), 64'(ST_FULL));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
